// File: rtl/lsu_mem_master_if.sv
// Request, memory-port and response signals shared by the execute stage,
// the load/store master and the memory.
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_en;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;

    modport master (
        input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata, req_rd,
        output req_ready,
        output mem_en, mem_rw, mem_addr, mem_wdata,
        input  mem_rdata,
        output rsp_valid, rsp_data, rsp_rd, rsp_err,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_store, req_size, req_signed, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  mem_en, mem_rw, mem_addr, mem_wdata,
        output mem_rdata,
        input  rsp_valid, rsp_data, rsp_rd, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store master for a word-wide memory without byte enables;
// sub-word stores are performed as read-modify-write.
module lsu_mem_master #(
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             nreset,
    lsu_mem_master_if.master bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        RESP     = 3'd4
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

    state_t      state_r;
    state_t      next_state_s;
    logic [2:0]  wait_cnt_r;
    logic        store_r;
    logic        signed_r;
    logic [1:0]  size_r;
    logic [1:0]  lane_r;
    logic [31:0] wdata_r;
    logic [4:0]  rd_r;

    logic        req_ready_r;
    logic        mem_en_r;
    logic        mem_rw_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_data_r;
    logic [4:0]  rsp_rd_r;
    logic        rsp_err_r;

    logic        accept_s;
    logic        misaligned_s;
    logic        word_store_s;
    logic        rd_done_s;
    logic [31:0] load_data_s;
    logic [31:0] merged_s;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = lane[0];
            default: mis = (lane != 2'd0);
        endcase
        return mis;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                                 input logic sgn, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    res = {{24{sgn & b[7]}}, b};
            2'd1:    res = {{16{sgn & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] res;
        res = old;
        case (size)
            2'd0: begin
                case (lane)
                    2'd0:    res[7:0]   = wd[7:0];
                    2'd1:    res[15:8]  = wd[7:0];
                    2'd2:    res[23:16] = wd[7:0];
                    default: res[31:24] = wd[7:0];
                endcase
            end
            2'd1: begin
                if (lane[1]) begin
                    res[31:16] = wd[15:0];
                end else begin
                    res[15:0] = wd[15:0];
                end
            end
            default: res = wd;
        endcase
        return res;
    endfunction

    // Next-state decode plus the load-extract and store-merge datapaths.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        misaligned_s = is_misaligned(bus.req_size, bus.req_addr[1:0]);
        word_store_s = bus.req_store & bus.req_size[1];
        rd_done_s    = (state_r == RD_WAIT) && (wait_cnt_r == 3'd0);
        load_data_s  = extract_load(bus.mem_rdata, size_r, signed_r, lane_r);
        merged_s     = merge_store(bus.mem_rdata, wdata_r, size_r, lane_r);
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_s = 1'b1;
                    if (misaligned_s) begin
                        next_state_s = RESP;
                    end else if (word_store_s) begin
                        next_state_s = WR_ISSUE;
                    end else begin
                        next_state_s = RD_ISSUE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD_ISSUE: next_state_s = RD_WAIT;
            RD_WAIT: begin
                if (wait_cnt_r == 3'd0) begin
                    next_state_s = store_r ? WR_ISSUE : RESP;
                end else begin
                    next_state_s = RD_WAIT;
                end
            end
            WR_ISSUE: next_state_s = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Captured request, read-wait counter and registered port outputs, all decoded from next state.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wait_cnt_r  <= 3'd0;
            store_r     <= 1'b0;
            signed_r    <= 1'b0;
            size_r      <= 2'd0;
            lane_r      <= 2'd0;
            wdata_r     <= 32'd0;
            rd_r        <= 5'd0;
            req_ready_r <= 1'b1;
            mem_en_r    <= 1'b0;
            mem_rw_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'd0;
            rsp_rd_r    <= 5'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            req_ready_r <= (next_state_s == IDLE);
            mem_en_r    <= (next_state_s == RD_ISSUE) || (next_state_s == WR_ISSUE);
            mem_rw_r    <= (next_state_s == WR_ISSUE);
            rsp_valid_r <= (next_state_s == RESP);

            if (accept_s) begin
                store_r    <= bus.req_store;
                signed_r   <= bus.req_signed;
                size_r     <= bus.req_size;
                lane_r     <= bus.req_addr[1:0];
                wdata_r    <= bus.req_wdata;
                rd_r       <= bus.req_rd;
                mem_addr_r <= {bus.req_addr[31:2], 2'b00};
            end

            if (state_r == RD_ISSUE) begin
                wait_cnt_r <= WAIT_INIT;
            end else if ((state_r == RD_WAIT) && (wait_cnt_r != 3'd0)) begin
                wait_cnt_r <= wait_cnt_r - 3'd1;
            end

            if (accept_s && !misaligned_s && word_store_s) begin
                mem_wdata_r <= bus.req_wdata;
            end else if (rd_done_s && store_r) begin
                mem_wdata_r <= merged_s;
            end

            // Stores and errors report rd=0/data=0; a load to x0 also returns zero data.
            if (accept_s && misaligned_s) begin
                rsp_err_r  <= 1'b1;
                rsp_data_r <= 32'd0;
                rsp_rd_r   <= 5'd0;
            end else if (rd_done_s && !store_r) begin
                rsp_err_r  <= 1'b0;
                rsp_data_r <= (rd_r == 5'd0) ? 32'd0 : load_data_s;
                rsp_rd_r   <= rd_r;
            end else if ((state_r == WR_ISSUE) || ((state_r == RESP) && bus.rsp_ready)) begin
                rsp_err_r  <= 1'b0;
                rsp_data_r <= 32'd0;
                rsp_rd_r   <= 5'd0;
            end
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_rw    = mem_rw_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_rd    = rsp_rd_r;
    assign bus.rsp_err   = rsp_err_r;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: two instances (read latency 1 and 3) against a word memory
// responder, with expected responses and strobes computed from load/store semantics.
module tb_lsu_mem_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nreset;
    logic        sel;
    logic        req_valid, req_store, req_signed, rsp_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    lsu_mem_master_if bus1 ();
    lsu_mem_master_if bus3 ();

    lsu_mem_master #(.RD_LAT(1)) dut1 (.clk(clk), .nreset(nreset), .bus(bus1.master));
    lsu_mem_master #(.RD_LAT(3)) dut3 (.clk(clk), .nreset(nreset), .bus(bus3.master));

    assign bus1.req_valid  = req_valid & ~sel;
    assign bus3.req_valid  = req_valid & sel;
    assign bus1.req_store  = req_store;
    assign bus3.req_store  = req_store;
    assign bus1.req_size   = req_size;
    assign bus3.req_size   = req_size;
    assign bus1.req_signed = req_signed;
    assign bus3.req_signed = req_signed;
    assign bus1.req_addr   = req_addr;
    assign bus3.req_addr   = req_addr;
    assign bus1.req_wdata  = req_wdata;
    assign bus3.req_wdata  = req_wdata;
    assign bus1.req_rd     = req_rd;
    assign bus3.req_rd     = req_rd;
    assign bus1.rsp_ready  = rsp_ready;
    assign bus3.rsp_ready  = rsp_ready;

    logic        obs_req_ready, obs_mem_en, obs_mem_rw, obs_rsp_valid, obs_rsp_err;
    logic [31:0] obs_mem_addr, obs_mem_wdata, obs_rsp_data;
    logic [4:0]  obs_rsp_rd;
    assign obs_req_ready = sel ? bus3.req_ready : bus1.req_ready;
    assign obs_mem_en    = sel ? bus3.mem_en    : bus1.mem_en;
    assign obs_mem_rw    = sel ? bus3.mem_rw    : bus1.mem_rw;
    assign obs_mem_addr  = sel ? bus3.mem_addr  : bus1.mem_addr;
    assign obs_mem_wdata = sel ? bus3.mem_wdata : bus1.mem_wdata;
    assign obs_rsp_valid = sel ? bus3.rsp_valid : bus1.rsp_valid;
    assign obs_rsp_data  = sel ? bus3.rsp_data  : bus1.rsp_data;
    assign obs_rsp_rd    = sel ? bus3.rsp_rd    : bus1.rsp_rd;
    assign obs_rsp_err   = sel ? bus3.rsp_err   : bus1.rsp_err;

    // 16-word memory: slots 0-7 at 0x00..0x1C, 8-14 at 0x80000000..0x80000018, 15 at 0xFFFFFFFC
    logic [31:0] mem [0:15];
    logic [31:0] ref_mem [0:15];
    logic [31:0] pipe1;
    logic [31:0] pipe3 [0:2];

    function automatic logic [3:0] midx(input logic [31:0] a);
        return {a[31], a[4:2]};
    endfunction

    function automatic logic [31:0] slot_addr(input int i);
        if (i == 15) return 32'hFFFFFFFC;
        else if (i >= 8) return 32'h80000000 + 32'(4 * (i - 8));
        else return 32'(4 * i);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: read data appears exactly RD_LAT cycles after the strobe, garbage otherwise.
    always @(posedge clk) begin
        pipe1    <= (bus1.mem_en && !bus1.mem_rw) ? mem[midx(bus1.mem_addr)] : $urandom;
        pipe3[0] <= (bus3.mem_en && !bus3.mem_rw) ? mem[midx(bus3.mem_addr)] : $urandom;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
        if (bus1.mem_en && bus1.mem_rw) mem[midx(bus1.mem_addr)] <= bus1.mem_wdata;
        if (bus3.mem_en && bus3.mem_rw) mem[midx(bus3.mem_addr)] <= bus3.mem_wdata;
    end
    assign bus1.mem_rdata = pipe1;
    assign bus3.mem_rdata = pipe3[2];

    typedef struct {
        int          cyc;
        int          inst;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } strobe_t;
    strobe_t seen_q[$];
    strobe_t exp_q[$];

    always @(negedge clk) begin
        if (bus1.mem_en === 1'b1) seen_q.push_back('{cyc, 1, bus1.mem_rw, bus1.mem_addr, bus1.mem_wdata});
        if (bus3.mem_en === 1'b1) seen_q.push_back('{cyc, 3, bus3.mem_rw, bus3.mem_addr, bus3.mem_wdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(obs_req_ready), 32'd1);
        chk({tag, "_mem_en"},    32'(obs_mem_en),    32'd0);
        chk({tag, "_mem_rw"},    32'(obs_mem_rw),    32'd0);
        chk({tag, "_mem_addr"},  obs_mem_addr,       32'd0);
        chk({tag, "_mem_wdata"}, obs_mem_wdata,      32'd0);
        chk({tag, "_rsp_valid"}, 32'(obs_rsp_valid), 32'd0);
        chk({tag, "_rsp_data"},  obs_rsp_data,       32'd0);
        chk({tag, "_rsp_rd"},    32'(obs_rsp_rd),    32'd0);
        chk({tag, "_rsp_err"},   32'(obs_rsp_err),   32'd0);
    endtask

    task automatic chk_strobes();
        chk("n_strobes", 32'(seen_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
            chk("strobe_cyc",  32'(seen_q[i].cyc),  32'(exp_q[i].cyc));
            chk("strobe_inst", 32'(seen_q[i].inst), 32'(exp_q[i].inst));
            chk("strobe_rw",   32'(seen_q[i].rw),   32'(exp_q[i].rw));
            chk("strobe_addr", seen_q[i].addr,      exp_q[i].addr);
            if (exp_q[i].rw) chk("strobe_wdata", seen_q[i].wdata, exp_q[i].wdata);
        end
        seen_q.delete();
        exp_q.delete();
    endtask

    // Issues one request at the current negedge and checks response timing, contents and strobes.
    task automatic run_req(input logic st, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd, input int stall,
                           output logic [31:0] got);
        int          lat, nb, off, slot, l, inst, t0, n;
        logic [31:0] old, v, mask, merged, exp_data, waddr;
        logic [4:0]  exp_rd;
        logic        exp_err;
        l     = sel ? 3 : 1;
        inst  = sel ? 3 : 1;
        nb    = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
        off   = int'(a[1:0]);
        slot  = int'(midx(a));
        waddr = a & 32'hFFFFFFFC;
        old   = ref_mem[slot];
        t0    = cyc;
        exp_data = 32'd0;
        exp_rd   = 5'd0;
        exp_err  = 1'b0;
        if ((off % nb) != 0) begin
            lat     = 1;
            exp_err = 1'b1;
        end else if (st && nb == 4) begin
            lat = 2;
            exp_q.push_back('{t0 + 1, inst, 1'b1, waddr, wd});
            ref_mem[slot] = wd;
        end else if (!st) begin
            lat = 2 + l;
            exp_q.push_back('{t0 + 1, inst, 1'b0, waddr, 32'd0});
            v = old >> (8 * off);
            if (nb == 1) begin
                v = v & 32'h000000FF;
                if (sg && v[7]) v = v | 32'hFFFFFF00;
            end else if (nb == 2) begin
                v = v & 32'h0000FFFF;
                if (sg && v[15]) v = v | 32'hFFFF0000;
            end
            exp_data = (rd == 5'd0) ? 32'd0 : v;
            exp_rd   = rd;
        end else begin
            lat    = 3 + l;
            mask   = ((nb == 1) ? 32'h000000FF : 32'h0000FFFF) << (8 * off);
            merged = (old & ~mask) | ((wd << (8 * off)) & mask);
            exp_q.push_back('{t0 + 1, inst, 1'b0, waddr, 32'd0});
            exp_q.push_back('{t0 + 2 + l, inst, 1'b1, waddr, merged});
            ref_mem[slot] = merged;
        end

        chk("req_ready_idle", 32'(obs_req_ready), 32'd1);
        req_store  = st;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
        req_valid  = 1'b1;
        rsp_ready  = (stall == 0);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_rd    = 5'($urandom);
        n = 0;
        while (obs_rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", 32'(cyc - t0), 32'(lat));
        got = obs_rsp_data;
        chk("rsp_data", obs_rsp_data, exp_data);
        chk("rsp_rd", 32'(obs_rsp_rd), 32'(exp_rd));
        chk("rsp_err", 32'(obs_rsp_err), 32'(exp_err));
        chk("req_ready_busy", 32'(obs_req_ready), 32'd0);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(obs_rsp_valid), 32'd1);
            chk("stall_data", obs_rsp_data, exp_data);
            chk("stall_rd", 32'(obs_rsp_rd), 32'(exp_rd));
            chk("stall_ready", 32'(obs_req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_hs_valid", 32'(obs_rsp_valid), 32'd0);
        chk("post_hs_ready", 32'(obs_req_ready), 32'd1);
        chk_strobes();
    endtask

    logic [31:0] got;
    int          t0r;

    initial begin
        nreset     = 1'b0;
        sel        = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_rd     = 5'd0;
        rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst1");
        sel = 1'b1;
        #1;
        chk_reset_outputs("rst3");
        @(negedge clk);
        nreset = 1'b1;
        sel    = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) run_req(1'b1, 2'd2, 1'b0, slot_addr(i), $urandom, 5'd0, 0, got);
        run_req(1'b1, 2'd2, 1'b0, 32'h80000004, 32'hDEADBEEF, 5'd0, 0, got);
        run_req(1'b1, 2'd2, 1'b0, 32'h80000000, 32'h11223344, 5'd0, 0, got);

        run_req(1'b0, 2'd2, 1'b0, 32'h80000004, 32'd0, 5'd5, 0, got);
        chk("lw_deadbeef", got, 32'hDEADBEEF);
        run_req(1'b0, 2'd0, 1'b1, 32'h80000007, 32'd0, 5'd1, 0, got);
        chk("lb_signed", got, 32'hFFFFFFDE);
        run_req(1'b0, 2'd1, 1'b0, 32'h80000006, 32'd0, 5'd2, 0, got);
        chk("lhu", got, 32'h0000DEAD);
        run_req(1'b0, 2'd0, 1'b0, 32'h80000004, 32'd0, 5'd3, 0, got);
        chk("lbu", got, 32'h000000EF);
        run_req(1'b1, 2'd0, 1'b0, 32'h80000001, 32'hA5A5A55A, 5'd0, 0, got);
        chk("sb_merged_word", mem[8], 32'h11225A44);
        run_req(1'b0, 2'd2, 1'b0, 32'h80000002, 32'd0, 5'd4, 0, got);
        run_req(1'b1, 2'd1, 1'b0, 32'h80000001, 32'h12345678, 5'd0, 0, got);
        run_req(1'b0, 2'd2, 1'b0, 32'h80000004, 32'd0, 5'd7, 5, got);
        run_req(1'b0, 2'd2, 1'b0, 32'h80000004, 32'd0, 5'd0, 0, got);
        run_req(1'b1, 2'd3, 1'b0, 32'hFFFFFFFC, 32'hCAFEF00D, 5'd0, 0, got);
        run_req(1'b0, 2'd0, 1'b1, 32'hFFFFFFFF, 32'd0, 5'd9, 0, got);
        chk("lb_top_byte", got, 32'hFFFFFFCA);

        sel = 1'b1;
        #1;
        run_req(1'b0, 2'd2, 1'b0, 32'h80000004, 32'd0, 5'd6, 0, got);
        run_req(1'b1, 2'd1, 1'b0, 32'h80000006, 32'hFFFF8001, 5'd0, 1, got);

        // Reset during the read wait of a halfword RMW must abandon the write.
        req_store  = 1'b1;
        req_size   = 2'd1;
        req_signed = 1'b0;
        req_addr   = 32'h80000002;
        req_wdata  = 32'h0000BEEF;
        req_rd     = 5'd0;
        req_valid  = 1'b1;
        t0r        = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        nreset = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        @(negedge clk);
        nreset = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_n_strobes", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() > 0) begin
            chk("rst_read_cyc", 32'(seen_q[0].cyc), 32'(t0r + 1));
            chk("rst_read_rw", 32'(seen_q[0].rw), 32'd0);
        end
        chk("rst_mem_unchanged", mem[8], ref_mem[8]);
        chk("rst_ready", 32'(obs_req_ready), 32'd1);
        seen_q.delete();
        run_req(1'b1, 2'd1, 1'b0, 32'h80000002, 32'h0000BEEF, 5'd0, 0, got);
        run_req(1'b0, 2'd2, 1'b0, 32'h80000000, 32'd0, 5'd8, 0, got);

        for (int r = 0; r < 60; r++) begin
            sel = 1'($urandom_range(0, 1));
            #1;
            run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    slot_addr($urandom_range(0, 15)) | 32'($urandom_range(0, 3)), $urandom,
                    ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    $urandom_range(0, 2), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
